ab_input_conditioner: RTL

Front-end stage that produces the a/b inputs of the two-input control FSM from raw, asynchronous, bouncing switch/pin signals.
- Per channel: 2-FF synchroniser, then debounce, then rising-edge strobe.
- A pairing FSM aligns near-coincident a/b events, so the downstream FSM sees a&b in the same cycle.
- Outputs are registered single-cycle pulses in clk domain.

---
 rtl/ab_cond_pkg.sv | 10 +
 rtl/ab_input_conditioner_debounce_ch.sv | 53 +++++
 rtl/ab_input_conditioner.sv | 99 +++++++++
 3 files changed

// File: rtl/ab_cond_pkg.sv
// Shared types for the a/b input conditioner: pairing FSM state encoding.
package ab_cond_pkg;

  typedef enum logic [1:0] {
    PC_IDLE   = 2'd0,
    PC_WAIT_A = 2'd1,
    PC_WAIT_B = 2'd2
  } pair_state_t;

endpackage

// File: rtl/ab_input_conditioner_debounce_ch.sv
// One input channel: 2-FF synchroniser, counter debounce, rising-edge strobe.
module debounce_ch #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic x_raw,
  output logic lvl,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             lvl_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= x_raw;
      s2 <= s1;
    end
  end

  // A disagreeing run must last DB_CYCLES samples; any agreeing sample restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
      if (s2 != lvl) begin
        if (cnt == CNT_LAST) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/ab_input_conditioner.sv
// Conditions raw a/b pins into one-cycle pulses, pairing events that land
// within PAIR_WIN cycles of each other so downstream logic sees a&b together.
module ab_input_conditioner
  import ab_cond_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int PAIR_WIN  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_lvl,
  output logic b_lvl
);

  localparam int TMR_W = $clog2(PAIR_WIN + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PAIR_WIN);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic        rise_a;
  logic        rise_b;
  pair_state_t state;
  logic [TMR_W-1:0] tmr;

  debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk  (clk),
    .rst  (rst),
    .x_raw(a_raw),
    .lvl  (a_lvl),
    .rise (rise_a)
  );

  debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk  (clk),
    .rst  (rst),
    .x_raw(b_raw),
    .lvl  (b_lvl),
    .rise (rise_b)
  );

  // Partner rise is tested before timer expiry so a last-moment partner still pairs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PC_IDLE;
      tmr   <= '0;
      a     <= 1'b0;
      b     <= 1'b0;
    end else begin
      a <= 1'b0;
      b <= 1'b0;
      case (state)
        PC_IDLE: begin
          if (rise_a && rise_b) begin
            a <= 1'b1;
            b <= 1'b1;
          end else if (rise_a) begin
            state <= PC_WAIT_B;
            tmr   <= TMR_LOAD;
          end else if (rise_b) begin
            state <= PC_WAIT_A;
            tmr   <= TMR_LOAD;
          end
        end
        PC_WAIT_B: begin
          if (rise_b) begin
            a     <= 1'b1;
            b     <= 1'b1;
            state <= PC_IDLE;
          end else if (tmr == TMR_ONE) begin
            a     <= 1'b1;
            state <= PC_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        PC_WAIT_A: begin
          if (rise_a) begin
            a     <= 1'b1;
            b     <= 1'b1;
            state <= PC_IDLE;
          end else if (tmr == TMR_ONE) begin
            b     <= 1'b1;
            state <= PC_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          state <= PC_IDLE;
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule
